// File: rtl/bconv_engine.sv
// Binary-weight KxK convolution engine: streams image columns through a K-column window,
// applies a +1/-1 kernel and reduces through a registered adder tree with output saturation.
module bconv_engine #(
  parameter int unsigned K       = 5,
  parameter int unsigned DW      = 16,
  parameter int unsigned OW      = 16,
  parameter int unsigned DIM_MAX = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [7:0]           img_w,
  input  logic [7:0]           img_h,
  input  logic                 w_load,
  input  logic                 w_valid,
  input  logic                 w_bit,
  output logic                 w_ready,
  input  logic [K*DW-1:0]      taps,
  input  logic                 tap_valid,
  output logic signed [OW-1:0] dout,
  output logic                 ovalid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NT = K * K;
  localparam int unsigned L  = $clog2(NT);
  localparam int unsigned AW = DW + L + 1;
  localparam int unsigned CW = $clog2(DIM_MAX);
  localparam int unsigned IW = $clog2(NT + 1);
  localparam int unsigned PW = L + 2;

  localparam logic signed [AW-1:0] SAT_HI = AW'({1'b0, {(OW-1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

  // Operand count at each adder-tree level; level 0 holds the K*K products.
  function automatic int unsigned lvl_cnt(input int unsigned l);
    int unsigned c;
    c = NT;
    for (int unsigned i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int unsigned lvl_off(input int unsigned l);
    int unsigned o;
    o = 0;
    for (int unsigned i = 0; i < l; i++) o = o + lvl_cnt(i);
    return o;
  endfunction

  localparam int unsigned NN = lvl_off(L + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [NT-1:0]       kbits;
  logic [IW-1:0]       kidx;
  logic [CW-1:0]       col, row;
  logic [7:0]          w_lim, h_lim;
  logic [PW-1:0]       vld, lst;
  logic                go, restart, accept;
  logic                win_ok, last_col;
  logic signed [DW-1:0] win [K][K];
  logic signed [AW-1:0] node [NN];
  logic signed [AW-1:0] sum;
  logic signed [OW-1:0] sat;

  assign win_ok   = (col >= CW'(K - 1)) && (row >= CW'(K - 1));
  assign last_col = (8'(col) == w_lim) && (8'(row) == h_lim);
  assign sum      = node[NN-1];
  assign sat      = (sum > SAT_HI) ? OW'(SAT_HI) : (sum < SAT_LO) ? OW'(SAT_LO) : OW'(sum);

  // Kernel bit loader; frozen while a frame is in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kbits   <= '0;
      kidx    <= '0;
      w_ready <= 1'b0;
    end else if (!busy) begin
      if (w_load) begin
        kidx    <= '0;
        w_ready <= 1'b0;
      end else if (w_valid && !w_ready) begin
        kbits[kidx] <= w_bit;
        kidx        <= kidx + IW'(1);
        if (kidx == IW'(NT - 1)) w_ready <= 1'b1;
      end
    end
  end

  // Frame FSM next-state and strobes.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    restart   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (start && w_ready) begin
        go        = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: if (start) begin
        go      = 1'b1;
        restart = 1'b1;
      end else if (tap_valid) begin
        accept = 1'b1;
        if (last_col) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (start) begin
        go        = 1'b1;
        restart   = 1'b1;
        state_nxt = S_RUN;
      end else if (done) begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      col    <= '0;
      row    <= '0;
      w_lim  <= '0;
      h_lim  <= '0;
      vld    <= '0;
      lst    <= '0;
      ovalid <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      if (go) begin
        w_lim <= img_w - 8'd1;
        h_lim <= img_h - 8'd1;
        col   <= '0;
        row   <= '0;
      end else if (accept) begin
        if (8'(col) == w_lim) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      // A restart kills every window still travelling down the tree.
      if (restart) begin
        vld    <= '0;
        lst    <= '0;
        ovalid <= 1'b0;
        done   <= 1'b0;
      end else begin
        vld    <= {vld[PW-2:0], accept & win_ok};
        lst    <= {lst[PW-2:0], accept & win_ok & last_col};
        ovalid <= vld[PW-1];
        done   <= vld[PW-1] & lst[PW-1];
        if (vld[PW-1]) dout <= sat;
      end
    end
  end

  // Column window, [column][row]; column 0 is the oldest.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned c = 0; c < K; c++)
        for (int unsigned r = 0; r < K; r++) win[c][r] <= '0;
    end else if (accept) begin
      for (int unsigned c = 0; c < K - 1; c++)
        for (int unsigned r = 0; r < K; r++) win[c][r] <= win[c+1][r];
      for (int unsigned r = 0; r < K; r++) win[K-1][r] <= taps[(K-1-r)*DW +: DW];
    end
  end

  // Signed products, sign-extended to AW so negating the most negative sample is exact.
  for (genvar kr = 0; kr < K; kr++) begin : g_prow
    for (genvar kc = 0; kc < K; kc++) begin : g_pcol
      localparam int unsigned IDX = kr * K + kc;
      logic signed [AW-1:0] x;
      assign x = AW'(win[kc][kr]);
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) node[IDX] <= '0;
        else       node[IDX] <= kbits[IDX] ? x : -x;
      end
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar j = 0; j < lvl_cnt(l + 1); j++) begin : g_node
      localparam int unsigned SRC = lvl_off(l) + 2 * j;
      localparam int unsigned DST = lvl_off(l + 1) + j;
      if (2 * j + 1 < lvl_cnt(l)) begin : g_add
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) node[DST] <= '0;
          else       node[DST] <= node[SRC] + node[SRC+1];
        end
      end else begin : g_pass
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) node[DST] <= '0;
          else       node[DST] <= node[SRC];
        end
      end
    end
  end

endmodule

// File: doc/bconv_engine.md
BCONV_ENGINE -- requirements
Module: bconv_engine

Interface
REQ-001 SHALL have parameter K, default 5: square kernel size, 2..7.
REQ-002 SHALL have parameter DW, default 16: signed input sample width.
REQ-003 SHALL have parameter OW, default 16: signed output width.
REQ-004 SHALL have parameter DIM_MAX, default 64: maximum image width/height; counters are clog2(DIM_MAX) bits.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a frame.
REQ-008 SHALL have port img_w  in  8  runtime image width, K..DIM_MAX, sampled on start.
REQ-009 SHALL have port img_h  in  8  runtime image height, K..DIM_MAX, sampled on start.
REQ-010 SHALL have port w_load  in  1  pulse that begins a kernel load.
REQ-011 SHALL have port w_valid  in  1  qualifies w_bit.
REQ-012 SHALL have port w_bit  in  1  kernel bit: 1 = +1, 0 = -1.
REQ-013 SHALL have port w_ready  out  1  all K*K kernel bits loaded.
REQ-014 SHALL have port taps  in  K*DW  one image column, row 0 in the MSB slice, signed.
REQ-015 SHALL have port tap_valid  in  1  qualifies taps.
REQ-016 SHALL have port dout  out  OW  signed convolution result.
REQ-017 SHALL have port ovalid  out  1  qualifies dout.
REQ-018 SHALL have port busy  out  1  frame in progress.
REQ-019 SHALL have port done  out  1  one-cycle end-of-frame pulse.

Function
REQ-020 Kernel load: w_load SHALL clear the bit index and w_ready; each w_valid SHALL store w_bit at index i, then increment.
REQ-021 Bit index i SHALL map row-major to kernel row i/K, column i%K; column 0 SHALL be the oldest column of the window.
REQ-022 After K*K bits, w_ready SHALL go to 1 and further w_valid SHALL be ignored until the next w_load.
REQ-023 w_load and w_valid SHALL be ignored while busy=1.
REQ-024 start with w_ready=1 and busy=0 SHALL latch img_w/img_h, clear the column and row counters, and set busy.
REQ-025 start with w_ready=0 SHALL be ignored.
REQ-026 start while busy=1 SHALL restart the frame: counters are cleared, in-flight pipeline valids are squashed, and done is not pulsed for the aborted frame.
REQ-027 The window SHALL be a K-column shift register that shifts only on tap_valid while busy; tap_valid while idle SHALL be ignored.
REQ-028 Counter col SHALL increment per accepted column and wrap at img_w-1 to 0; row SHALL increment on that wrap.
REQ-029 A window SHALL be valid when col>=K-1 and row>=K-1, evaluated on the accepted column.
REQ-030 The product for each tap SHALL be +x when its weight bit is 1 and -x when it is 0, computed in full precision AW=DW+clog2(K*K)+1; -(-2^(DW-1)) SHALL NOT overflow.
REQ-031 Summation SHALL be a registered binary adder tree of clog2(K*K) levels; odd operands at a level pass through a register.
REQ-032 The final stage SHALL saturate the AW-bit sum to [-2^(OW-1), 2^(OW-1)-1] and register it to dout.
REQ-033 Latency SHALL be fixed: LAT = clog2(K*K)+2 cycles from the accepting tap_valid edge to ovalid, with no stall; K=5 gives LAT=7.
REQ-034 ovalid SHALL pulse once per valid window, giving exactly (img_w-K+1)*(img_h-K+1) pulses per frame.
REQ-035 done SHALL pulse in the same cycle as the last ovalid of the frame; busy SHALL clear in the following cycle.
REQ-036 dout SHALL hold its value when ovalid=0.
REQ-037 Gaps in tap_valid SHALL NOT alter any result; only cycle timing shifts.

Reset
REQ-038 On rstn=0, w_ready, busy, ovalid and done SHALL be 0, dout SHALL be 0, all kernel bits SHALL be 0, and counters and pipeline valids SHALL be cleared.
REQ-039 Reset mid-frame SHALL abandon the frame; the first legal start after reset SHALL operate normally once the kernel is reloaded.

Verification
REQ-040 K=5: load 25 ones, then an 8x8 image with all samples 3 and tap_valid every cycle -> 16 ovalid, each dout=75; first ovalid 7 cycles after column col=4 of row 4 is accepted; done with the 16th.
REQ-041 Load all zeros, all samples 3 -> each dout=-75; samples -32768 with all-zero weights, OW=16 -> dout saturates to 32767.
REQ-042 Kernel with only bit 0 set (all other bits 0), and an impulse of 100 at (r0,c0) -> the window at (0,0) gives dout = 100 + (-0) = 100; other windows covering the impulse give -100.
REQ-043 Random 50% tap_valid gaps versus a gap-free run on the same 12x12 image -> identical dout sequence and 64 outputs.
REQ-044 start with w_ready=0 -> busy stays 0; start mid-frame -> no done for the first frame, and the second frame completes correctly; w_valid while busy -> kernel unchanged.
REQ-045 rstn asserted mid-frame -> all outputs 0 within the same cycle; after reload and start, the frame matches the reference model.
